// File: rtl/qpp_ind_gen.sv
// QPP interleaver index generator: emits (i, pi(i)) per cycle, pi computed incrementally.
// Optional downstream stall enabled by defining QPP_IND_GEN_HOLD_EN.
module qpp_ind_gen #(
  parameter int unsigned IDX_W    = 14,
  parameter int unsigned K_SMALL  = 1056,
  parameter int unsigned F1_SMALL = 17,
  parameter int unsigned F2_SMALL = 66,
  parameter int unsigned K_LARGE  = 6144,
  parameter int unsigned F1_LARGE = 263,
  parameter int unsigned F2_LARGE = 480
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             k,
  input  logic             ready,
  input  logic             hold,
  output logic [IDX_W-1:0] out,
  output logic [IDX_W-1:0] out_pi,
  output logic             valid,
  output logic             k_out,
  output logic             done
);

  typedef enum logic [1:0] {StIdle, StCount, StDone1, StDone2} state_e;

  localparam logic [IDX_W:0]   KSmall    = (IDX_W + 1)'(K_SMALL);
  localparam logic [IDX_W:0]   KLarge    = (IDX_W + 1)'(K_LARGE);
  localparam logic [IDX_W-1:0] LastSmall = IDX_W'(K_SMALL - 1);
  localparam logic [IDX_W-1:0] LastLarge = IDX_W'(K_LARGE - 1);
  localparam logic [IDX_W-1:0] G0Small   = IDX_W'((F1_SMALL + F2_SMALL) % K_SMALL);
  localparam logic [IDX_W-1:0] G0Large   = IDX_W'((F1_LARGE + F2_LARGE) % K_LARGE);
  localparam logic [IDX_W-1:0] DSmall    = IDX_W'((2 * F2_SMALL) % K_SMALL);
  localparam logic [IDX_W-1:0] DLarge    = IDX_W'((2 * F2_LARGE) % K_LARGE);

  state_e           state_q;
  logic [IDX_W-1:0] cnt_q;
  logic [IDX_W-1:0] pi_q;
  logic [IDX_W-1:0] g_q;
  logic             kout_q;
  logic             valid_q;
  logic             done_q;

  logic [IDX_W:0]   k_mod;
  logic [IDX_W-1:0] k_last;
  logic [IDX_W-1:0] d_sel;
  logic [IDX_W-1:0] pi_next;
  logic [IDX_W-1:0] g_next;
  logic             step;

  // Both operands are already reduced, so a single conditional subtract suffices.
  function automatic logic [IDX_W-1:0] mod_add(input logic [IDX_W-1:0] a,
                                               input logic [IDX_W-1:0] b,
                                               input logic [IDX_W:0]   m);
    logic [IDX_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= m) begin
      sum = sum - m;
    end
    return sum[IDX_W-1:0];
  endfunction

`ifdef QPP_IND_GEN_HOLD_EN
  assign step = ~hold;
`else
  logic unused_hold;
  assign unused_hold = hold;
  assign step        = 1'b1;
`endif

  always_comb begin
    k_mod   = kout_q ? KLarge : KSmall;
    k_last  = kout_q ? LastLarge : LastSmall;
    d_sel   = kout_q ? DLarge : DSmall;
    pi_next = mod_add(pi_q, g_q, k_mod);
    g_next  = mod_add(g_q, d_sel, k_mod);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      pi_q    <= '0;
      g_q     <= '0;
      kout_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          cnt_q <= '0;
          pi_q  <= '0;
          if (ready) begin
            kout_q  <= k;
            g_q     <= k ? G0Large : G0Small;
            valid_q <= 1'b1;
            state_q <= StCount;
          end
        end
        StCount: begin
          if (step) begin
            if (cnt_q == k_last) begin
              valid_q <= 1'b0;
              done_q  <= 1'b1;
              state_q <= StDone1;
            end else begin
              cnt_q <= cnt_q + IDX_W'(1);
              pi_q  <= pi_next;
              g_q   <= g_next;
            end
          end
        end
        StDone1: begin
          state_q <= StDone2;
        end
        StDone2: begin
          // Clear here so the first IDLE cycle already shows zero indices.
          cnt_q   <= '0;
          pi_q    <= '0;
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          valid_q <= 1'b0;
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign out    = cnt_q;
  assign out_pi = pi_q;
  assign valid  = valid_q;
  assign done   = done_q;
  assign k_out  = kout_q;

endmodule
